// File: rtl/axi_stream_strip_header_pkg.sv
// Shared types, widths and keep helpers for axi_stream_strip_header.
// Byte order is MSB-first: stream byte 0 sits in data[DATA_WD-1 -: 8],
// and keep bit DATA_BYTE_WD-1 qualifies that byte.
package axi_stream_strip_header_pkg;

  localparam int unsigned DATA_WD      = 32;
  localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;

  // n leading (MSB-side) enables set
  function automatic logic [DATA_BYTE_WD-1:0] keep_from_cnt_msb(input int unsigned n);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (i < n);
    return k;
  endfunction

  // n trailing (LSB-side) enables set
  function automatic logic [DATA_BYTE_WD-1:0] keep_from_cnt_lsb(input int unsigned n);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [BYTE_CNT_WD:0] popcount(input logic [DATA_BYTE_WD-1:0] v);
    logic [BYTE_CNT_WD:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) c = c + {{BYTE_CNT_WD{1'b0}}, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// One AXI-Stream channel: valid/ready handshake with data, keep and last.
//   master: drives valid/data/keep/last, samples ready
//   slave : samples valid/data/keep/last, drives ready
interface axi_stream_strip_header_if;
  import axi_stream_strip_header_pkg::*;

  logic                    valid;
  logic                    ready;
  logic [DATA_WD-1:0]      data;
  logic [DATA_BYTE_WD-1:0] keep;
  logic                    last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axis_byte_align.sv
// Combinational byte realignment for header stripping.
//   res_data/res_keep : residue bytes held MSB-aligned (W-n bytes)
//   in_data/in_keep   : incoming beat
//   n                 : header length in bytes
//   out_data/out_keep : residue followed by the top n bytes of the beat
//   nxt_data/nxt_keep : bytes of the beat past the top n, MSB-aligned
// Disabled input bytes are zeroed first so unused output bytes stay 0.
module axis_byte_align
  import axi_stream_strip_header_pkg::*;
(
  input  logic [DATA_WD-1:0]      res_data,
  input  logic [DATA_BYTE_WD-1:0] res_keep,
  input  logic [DATA_WD-1:0]      in_data,
  input  logic [DATA_BYTE_WD-1:0] in_keep,
  input  logic [BYTE_CNT_WD:0]    n,
  output logic [DATA_WD-1:0]      out_data,
  output logic [DATA_BYTE_WD-1:0] out_keep,
  output logic [DATA_WD-1:0]      nxt_data,
  output logic [DATA_BYTE_WD-1:0] nxt_keep
);

  logic [DATA_WD-1:0] in_mask;
  logic [DATA_WD-1:0] in_clean;
  int unsigned        res_bytes;

  always_comb begin
    in_mask = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) in_mask[8*i +: 8] = {8{in_keep[i]}};
    in_clean  = in_data & in_mask;
    res_bytes = DATA_BYTE_WD - n;
    // Shifts of a full width or more yield 0, covering n = 0 and n = W.
    out_data  = res_data | (in_clean >> (8 * res_bytes));
    out_keep  = res_keep | (in_keep >> res_bytes);
    nxt_data  = in_clean << (8 * n);
    nxt_keep  = in_keep << n;
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte (0..W) header from each AXI-Stream packet, returns it
// right-aligned on the header channel and realigns the payload to full beats.
//   clk, rst_n                    : clock, async active-low reset
//   valid_strip/ready_strip       : one descriptor per packet
//   byte_strip_cnt                : header length N
//   axis_in  (slave)              : input packet stream
//   axis_out (master)             : realigned payload stream
//   axis_hdr (master)             : extracted header (last unused, tied 0)
module axi_stream_strip_header
  import axi_stream_strip_header_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_strip,
  output logic                      ready_strip,
  input  logic [BYTE_CNT_WD:0]      byte_strip_cnt,
  axi_stream_strip_header_if.slave  axis_in,
  axi_stream_strip_header_if.master axis_out,
  axi_stream_strip_header_if.master axis_hdr
);

  state_t                  state_q, state_d;
  logic [BYTE_CNT_WD:0]    n_q, n_d;
  logic [DATA_WD-1:0]      res_data_q, res_data_d;
  logic [DATA_BYTE_WD-1:0] res_keep_q, res_keep_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WD-1:0]      out_data_q, out_data_d;
  logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
  logic                    out_last_q, out_last_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

  logic                    out_free, hdr_free, in_ready, in_fire, tail_spill;
  logic [DATA_WD-1:0]      al_res_data, al_out_data, al_nxt_data;
  logic [DATA_BYTE_WD-1:0] al_res_keep, al_out_keep, al_nxt_keep;

  // In FIRST the aligner sees an empty residue, so its merged output is the
  // header right-aligned and its next-residue is the post-header payload.
  assign al_res_data = (state_q == FIRST) ? '0 : res_data_q;
  assign al_res_keep = (state_q == FIRST) ? '0 : res_keep_q;

  axis_byte_align u_align (
    .res_data (al_res_data),
    .res_keep (al_res_keep),
    .in_data  (axis_in.data),
    .in_keep  (axis_in.keep),
    .n        (n_q),
    .out_data (al_out_data),
    .out_keep (al_out_keep),
    .nxt_data (al_nxt_data),
    .nxt_keep (al_nxt_keep)
  );

  always_comb begin
    out_free = !out_valid_q || axis_out.ready;
    hdr_free = !hdr_valid_q || axis_hdr.ready;
    case (state_q)
      FIRST:   in_ready = out_free && hdr_free;
      BODY:    in_ready = out_free;
      default: in_ready = 1'b0;
    endcase
    in_fire    = axis_in.valid && in_ready;
    tail_spill = popcount(axis_in.keep) > n_q;

    state_d     = state_q;
    n_d         = n_q;
    res_data_d  = res_data_q;
    res_keep_d  = res_keep_q;
    out_valid_d = out_valid_q && !axis_out.ready;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    hdr_valid_d = hdr_valid_q && !axis_hdr.ready;
    hdr_data_d  = hdr_data_q;
    hdr_keep_d  = hdr_keep_q;

    case (state_q)
      IDLE: begin
        if (valid_strip) begin
          n_d     = byte_strip_cnt;
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (in_fire) begin
          hdr_valid_d = 1'b1;
          hdr_data_d  = al_out_data;
          hdr_keep_d  = keep_from_cnt_lsb(n_q);
          res_data_d  = al_nxt_data;
          res_keep_d  = al_nxt_keep;
          if (axis_in.last) begin
            state_d = IDLE;
            if (tail_spill) begin
              out_valid_d = 1'b1;
              out_data_d  = al_nxt_data;
              out_keep_d  = al_nxt_keep;
              out_last_d  = 1'b1;
            end
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = al_out_data;
          out_keep_d  = al_out_keep;
          out_last_d  = axis_in.last && !tail_spill;
          res_data_d  = al_nxt_data;
          res_keep_d  = al_nxt_keep;
          if (axis_in.last) state_d = tail_spill ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = res_data_q;
          out_keep_d  = res_keep_q;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      res_data_q  <= '0;
      res_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= '0;
      hdr_keep_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      res_data_q  <= res_data_d;
      res_keep_q  <= res_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_data_q  <= hdr_data_d;
      hdr_keep_q  <= hdr_keep_d;
    end
  end

  assign ready_strip    = (state_q == IDLE);
  assign axis_in.ready  = in_ready;
  assign axis_out.valid = out_valid_q;
  assign axis_out.data  = out_data_q;
  assign axis_out.keep  = out_keep_q;
  assign axis_out.last  = out_last_q;
  assign axis_hdr.valid = hdr_valid_q;
  assign axis_hdr.data  = hdr_data_q;
  assign axis_hdr.keep  = hdr_keep_q;
  assign axis_hdr.last  = 1'b0;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
`timescale 1ns/1ps
module tb_axi_stream_strip_header;
  import axi_stream_strip_header_pkg::*;

  localparam int W = int'(DATA_BYTE_WD);

  typedef logic [DATA_WD-1:0]   word_t;
  typedef logic [BYTE_CNT_WD:0] cnt_t;
  typedef logic [W-1:0]         keep_t;
  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [W-1:0]       keep;
    logic               last;
  } beat_t;

  logic clk, rst_n;
  logic valid_strip, ready_strip;
  cnt_t byte_strip_cnt;

  axi_stream_strip_header_if axis_in ();
  axi_stream_strip_header_if axis_out ();
  axi_stream_strip_header_if axis_hdr ();

  axi_stream_strip_header dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_strip    (valid_strip),
    .ready_strip    (ready_strip),
    .byte_strip_cnt (byte_strip_cnt),
    .axis_in        (axis_in),
    .axis_out       (axis_out),
    .axis_hdr       (axis_hdr)
  );

  int    n_tests, n_fail;
  beat_t exp_out[$];
  beat_t exp_hdr[$];
  logic [7:0] pkt[$];
  int    out_mode;   // 0 always ready, 1 toggle, 2 random, 3 held low
  logic  hdr_block, hdr_rand, gaps;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid_out"},   word_t'(axis_out.valid), '0);
    check({tag, "_last_out"},    word_t'(axis_out.last),  '0);
    check({tag, "_data_out"},    axis_out.data,           '0);
    check({tag, "_keep_out"},    word_t'(axis_out.keep),  '0);
    check({tag, "_valid_hdr"},   word_t'(axis_hdr.valid), '0);
    check({tag, "_data_hdr"},    axis_hdr.data,           '0);
    check({tag, "_keep_hdr"},    word_t'(axis_hdr.keep),  '0);
    check({tag, "_ready_in"},    word_t'(axis_in.ready),  '0);
    check({tag, "_ready_strip"}, word_t'(ready_strip),    word_t'(1));
  endtask

  // Reference model: header = first N packet bytes right-aligned (absent
  // bytes read as 0), payload = remaining bytes packed W per beat.
  task automatic send_pkt(input int n, input int stop_after);
    logic [7:0] b[$];
    int total, beats, cnt, budget;
    logic hs;
    beat_t e;
    word_t d;
    keep_t kp;
    b = pkt;
    total = b.size();
    beats = (total + W - 1) / W;

    e.data = '0;
    for (int j = 0; j < n; j++) e.data = {e.data[DATA_WD-9:0], (j < total) ? b[j] : 8'h00};
    e.keep = W'((1 << n) - 1);
    e.last = 1'b0;
    exp_hdr.push_back(e);
    for (int s = n; s < total; s += W) begin
      cnt = (total - s < W) ? total - s : W;
      e.data = '0;
      for (int j = 0; j < cnt; j++) e.data[DATA_WD-1-8*j -: 8] = b[s+j];
      e.keep = W'(((1 << cnt) - 1) << (W - cnt));
      e.last = (s + W >= total);
      exp_out.push_back(e);
    end

    @(negedge clk);
    valid_strip = 1'b1;
    byte_strip_cnt = cnt_t'(n);
    hs = 1'b0;
    for (budget = 0; budget < 200; budget++) begin
      #2;
      if (ready_strip) begin hs = 1'b1; break; end
      @(negedge clk);
    end
    check("strip_accept", word_t'(hs), word_t'(1));
    if (!hs) begin valid_strip = 1'b0; return; end
    @(posedge clk);

    for (int bt = 0; bt < beats && bt < stop_after; bt++) begin
      @(negedge clk);
      valid_strip = 1'b0;
      while (gaps && $urandom_range(0, 3) == 0) begin
        axis_in.valid = 1'b0;
        @(negedge clk);
      end
      d = '0;
      kp = '0;
      for (int j = 0; j < W; j++) begin
        if (bt * W + j < total) begin
          d[DATA_WD-1-8*j -: 8] = b[bt*W+j];
          kp[W-1-j] = 1'b1;
        end else begin
          d[DATA_WD-1-8*j -: 8] = 8'($urandom);
        end
      end
      axis_in.valid = 1'b1;
      axis_in.data  = d;
      axis_in.keep  = kp;
      axis_in.last  = (bt == beats - 1);
      hs = 1'b0;
      for (budget = 0; budget < 400; budget++) begin
        #2;
        if (axis_in.ready) begin hs = 1'b1; break; end
        @(negedge clk);
      end
      check("beat_accept", word_t'(hs), word_t'(1));
      if (!hs) begin axis_in.valid = 1'b0; return; end
      @(posedge clk);
    end
    @(negedge clk);
    valid_strip = 1'b0;
    axis_in.valid = 1'b0;
  endtask

  task automatic rand_pkt(input int total);
    pkt.delete();
    for (int i = 0; i < total; i++) pkt.push_back(8'($urandom));
  endtask

  // Output-stream monitor: drives ready_out, checks accepted beats and
  // stability while stalled.
  initial begin
    logic  stall;
    beat_t held, e;
    int    tog;
    stall = 1'b0;
    tog = 0;
    held = '0;
    axis_out.ready = 1'b0;
    forever begin
      @(negedge clk);
      case (out_mode)
        0: axis_out.ready = 1'b1;
        1: begin axis_out.ready = tog[0]; tog++; end
        3: axis_out.ready = 1'b0;
        default: axis_out.ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (!rst_n) begin stall = 1'b0; continue; end
      if (stall) begin
        check("out_stable_data", axis_out.data, held.data);
        check("out_stable_keep", word_t'(axis_out.keep), word_t'(held.keep));
        check("out_stable_last", word_t'(axis_out.last), word_t'(held.last));
      end
      if (axis_out.valid && axis_out.ready) begin
        check("out_beat_expected", word_t'(exp_out.size() != 0), word_t'(1));
        if (exp_out.size() != 0) begin
          e = exp_out.pop_front();
          check("out_data", axis_out.data, e.data);
          check("out_keep", word_t'(axis_out.keep), word_t'(e.keep));
          check("out_last", word_t'(axis_out.last), word_t'(e.last));
        end
      end
      stall = axis_out.valid && !axis_out.ready;
      held = {axis_out.data, axis_out.keep, axis_out.last};
    end
  end

  // Header-stream monitor.
  initial begin
    logic  stall;
    beat_t held, e;
    stall = 1'b0;
    held = '0;
    axis_hdr.ready = 1'b0;
    forever begin
      @(negedge clk);
      if (hdr_block) axis_hdr.ready = 1'b0;
      else if (hdr_rand) axis_hdr.ready = ($urandom_range(0, 2) != 0);
      else axis_hdr.ready = 1'b1;
      #1;
      if (!rst_n) begin stall = 1'b0; continue; end
      if (stall) begin
        check("hdr_stable_data", axis_hdr.data, held.data);
        check("hdr_stable_keep", word_t'(axis_hdr.keep), word_t'(held.keep));
      end
      if (axis_hdr.valid && axis_hdr.ready) begin
        check("hdr_beat_expected", word_t'(exp_hdr.size() != 0), word_t'(1));
        if (exp_hdr.size() != 0) begin
          e = exp_hdr.pop_front();
          check("hdr_data", axis_hdr.data, e.data);
          check("hdr_keep", word_t'(axis_hdr.keep), word_t'(e.keep));
        end
      end
      stall = axis_hdr.valid && !axis_hdr.ready;
      held = {axis_hdr.data, axis_hdr.keep, 1'b0};
    end
  end

  // Flag unsupported input: non-contiguous keep, or empty keep on last.
  always @(posedge clk) begin
    if (rst_n && axis_in.valid && axis_in.ready) begin
      assert (axis_in.keep == keep_from_cnt_msb(32'(popcount(axis_in.keep))))
        else $error("unsupported keep_in %b", axis_in.keep);
      assert (!axis_in.last || axis_in.keep != '0)
        else $error("empty keep_in on last beat");
    end
  end

  initial begin
    int budget;
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    valid_strip = 1'b0;
    byte_strip_cnt = '0;
    axis_in.valid = 1'b0;
    axis_in.data = '0;
    axis_in.keep = '0;
    axis_in.last = 1'b0;
    out_mode = 0;
    hdr_block = 1'b0;
    hdr_rand = 1'b0;
    gaps = 1'b0;

    repeat (3) @(negedge clk);
    #2 check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // N=2 across three beats, last beat two bytes
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(2, 99);

    // N=1 with tail flush; ready_in must stay low while the flush beat waits
    out_mode = 3;
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33};
    send_pkt(1, 99);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      axis_in.valid = 1'b1;
      axis_in.keep  = '1;
      #2 check("ready_in_flush", word_t'(axis_in.ready), '0);
    end
    @(negedge clk);
    axis_in.valid = 1'b0;
    out_mode = 0;

    // N=3, header-only single beat
    pkt = '{8'hDE, 8'hAD, 8'hBE};
    send_pkt(3, 99);

    // N=0 and N=W on three full beats
    rand_pkt(12);
    send_pkt(0, 99);
    rand_pkt(12);
    send_pkt(W, 99);

    // Output backpressure toggling over a 6-beat packet
    out_mode = 1;
    rand_pkt(24);
    send_pkt(2, 99);
    out_mode = 0;

    // Header channel blocked: next packet's first beat must wait
    hdr_block = 1'b1;
    fork
      begin
        rand_pkt(7);
        send_pkt(1, 99);
        rand_pkt(8);
        send_pkt(2, 99);
      end
      begin
        repeat (14) @(negedge clk);
        #3;
        check("ready_in_hdr_stall", word_t'(axis_in.ready), '0);
        check("hdr_held_valid", word_t'(axis_hdr.valid), word_t'(1));
        hdr_block = 1'b0;
      end
    join

    // Reset in the middle of a packet body
    rand_pkt(24);
    send_pkt(2, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #2 check_idle_outputs("midreset");
    exp_out.delete();
    exp_hdr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rand_pkt(10);
    send_pkt(2, 99);

    // Randomized packets under random flow control
    gaps = 1'b1;
    for (int p = 0; p < 40; p++) begin
      out_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      hdr_rand = $urandom_range(0, 1);
      rand_pkt($urandom_range(1, 18));
      send_pkt($urandom_range(0, W), 99);
    end
    out_mode = 0;
    hdr_rand = 1'b0;

    for (budget = 0; budget < 500; budget++) begin
      @(negedge clk);
      if (exp_out.size() == 0 && exp_hdr.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check("drain_out", word_t'(exp_out.size()), '0);
    check("drain_hdr", word_t'(exp_hdr.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Removes a per-packet header of 0..DATA_BYTE_WD leading bytes from an AXI-Stream packet and realigns the remaining payload to full output beats. The removed bytes are returned on a separate header stream. It sits on the receive side of links whose transmit side prepends headers with `axi_stream_insert_header`. Byte order is MSB-first: stream byte 0 is `data[DATA_WD-1 -: 8]`, and a partial beat's `keep` is MSB-contiguous.

## Interface
- DATA_WD, 32, data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-index width
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- valid_strip / ready_strip  in / out  1  strip-descriptor handshake, one descriptor per packet
- byte_strip_cnt  in  BYTE_CNT_WD+1  header length N, 0..DATA_BYTE_WD
- valid_in / ready_in  in / out  1  input stream handshake
- data_in  in  DATA_WD  input data
- keep_in  in  DATA_BYTE_WD  input byte enables; all ones except on the last beat
- last_in  in  1  last beat of the input packet
- valid_out / ready_out  out / in  1  output stream handshake
- data_out  out  DATA_WD  output data
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-contiguous
- last_out  out  1  last beat of the output packet
- valid_hdr / ready_hdr  out / in  1  extracted-header handshake
- data_hdr  out  DATA_WD  header bytes, right-aligned (LSB side)
- keep_hdr  out  DATA_BYTE_WD  header enables: low N bits set

## Operation
- States and transitions:
  - IDLE goes to FIRST on a strip-descriptor handshake; N is latched. `ready_strip` = (state==IDLE).
  - FIRST goes to BODY on a non-last beat.
  - FIRST goes to IDLE on a last beat.
  - BODY goes to FLUSH on a last beat with k>N, where k = popcount(keep_in).
  - BODY goes to IDLE on a last beat with k≤N.
  - FLUSH goes to IDLE when the tail beat is loaded.
- ready_in:
  - In FIRST: `ready_in` = (!valid_out||ready_out) && (!valid_hdr||ready_hdr).
  - In BODY: `ready_in` = (!valid_out||ready_out).
  - In IDLE and FLUSH: `ready_in` = 0.
- Residue register: holds the trailing bytes of the previous beat. Count r = W-N in BODY, where W = DATA_BYTE_WD.
- FIRST beat:
  - The top N bytes go to the header register (right-aligned), which drives `valid_hdr`. For N=0, the header beat is still emitted with `keep_hdr`=0.
  - The remaining W-N bytes go to the residue register.
  - On a last beat with k>N: emit k-N bytes with `last_out`.
  - On a last beat with k≤N: emit no data beat (header-only packet).
- BODY, non-last beat: emit {residue, top N bytes}, `keep_out`=all ones. The residue becomes the low W-N bytes of this beat.
- BODY, last beat:
  - W-N+k ≤ W: emit a single beat, `keep_out` = top (W-N+k) bits, `last_out`=1.
  - Otherwise: emit a full beat now, then in FLUSH emit the remaining k-N bytes with `last_out`=1.
- Edge values of N: N=0 gives a one-beat-delayed passthrough with the tail always flushed. N=W makes the first beat all header; later beats pass through aligned.
- Unused output bytes are driven to 0.
- Unsupported input: non-contiguous `keep_in`, and `keep_in`=0 on a last beat. Behaviour is unspecified for both; the bench flags them with an assertion.

## Timing
- Reset values:
  - `valid_out`, `last_out`, `valid_hdr` = 0.
  - `data_out`, `keep_out`, `data_hdr`, `keep_hdr` = 0.
  - `ready_in` = 0.
  - `ready_strip` = 1.
  - State = IDLE.
- A descriptor accepted in cycle t makes `ready_in` eligible from t+1.
- Input and output latency:
  - An input beat accepted in cycle t makes its header / completed output beat visible at t+1 (registered).
  - A FLUSH beat appears one cycle after the preceding full beat is accepted downstream.
- Full throughput: one beat per cycle in BODY with `ready_out` held at 1.
- Output is stable while `valid_out && !ready_out`. The same applies to the header outputs.
- The next packet's descriptor can be accepted while the previous packet's final beat still waits in the output register.
- Reset mid-packet clears the state, residue and both output registers immediately. The partial packet is discarded, and input is ignored until a new descriptor arrives.

## Structure
- Package `axi_stream_strip_header_pkg` holds:
  - the state enum {IDLE, FIRST, BODY, FLUSH};
  - the width constants;
  - the functions keep_from_cnt_msb(n) and keep_from_cnt_lsb(n), plus popcount.
- Sub-module `axis_byte_align`: a combinational merge of the residue and the incoming beat for a given N, producing the data/keep of the output beat and the next residue.

## Test plan
- N=2; beats 0xAABBCCDD, 0x11223344, last 0x55667788 keep 4'b1100 -> hdr 0x0000AABB keep 4'b0011. Output 0xCCDD1122 keep f, then 0x33445566 keep f with last.
- N=1; beats 0xAABBCCDD, last 0x11223344 keep 4'b1110 -> output 0xBBCCDD11 keep f, then FLUSH 0x22330000 keep 4'b1100 with last. `ready_in` is 0 during FLUSH.
- N=3; single last beat 0xDEADBEEF keep 4'b1110 -> hdr 0x00DEADBE keep 4'b0111. `valid_out` never asserts; the state returns to IDLE.
- N=0 and N=4 packets of 3 full beats:
  - N=0 -> data passed unchanged, one-cycle extra delay, hdr keep 0.
  - N=4 -> hdr = beat 0, and beats 1–2 are output unchanged.
- Backpressure: `ready_out` toggles 1/0 over a 6-beat N=2 packet -> no loss, `data_out` stable while stalled. With `ready_hdr`=0, `ready_in` stays 0 in FIRST until the header is taken.
- `rst_n` pulsed low mid-BODY -> all valids 0 next edge and `ready_strip`=1. A following N=2 packet is processed correctly.
